// File: rtl/ram_readout_streamer_if.sv
// Bundle for the RAM read port and the outbound valid/ready stream of ram_readout_streamer.
// The streamer holds the master side; the RAM and the host-link consumer hold the slave side.
interface ram_readout_streamer_if #(
  parameter int W  = 33,
  parameter int AW = 14
);
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_q;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output ram_addr,
    input  ram_q,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  ram_addr,
    output ram_q,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/ram_readout_streamer.sv
// Sequential RAM readout onto a valid/ready stream, absorbing a fixed RAM read latency.
// Optional trailing XOR checksum word when READOUT_CHECKSUM_EN is defined.
module ram_readout_streamer #(
  parameter int NO_OF_DIGITS    = 10,
  parameter int RADIX_BITS      = 3,
  parameter int ADDRESS_WIDTH   = 14,
  parameter int MAX_RAM_ADDRESS = 4096,
  parameter int READ_LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  ram_readout_streamer_if.master bus,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int W  = (NO_OF_DIGITS + 1) * RADIX_BITS;
  localparam int CW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  localparam logic [CW-1:0]            CNT_LOAD  = CW'(READ_LATENCY);
  localparam logic [CW-1:0]            CNT_ONE   = CW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MAX_RAM_ADDRESS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

  // state | meaning
  // IDLE  | waiting for start after reset
  // FETCH | address issued, counting down the RAM read latency
  // SEND  | data word presented, waiting for out_ready
  // CHK   | checksum word presented (checksum build only)
  // DONE  | readout complete, done held until the next start
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef READOUT_CHECKSUM_EN
  localparam logic [2:0] S_CHK        = 3'd3;
  localparam logic [2:0] S_AFTER_LAST = S_CHK;
`else
  localparam logic [2:0] S_AFTER_LAST = S_DONE;
`endif

  logic [2:0]               r_state;
  logic [CW-1:0]            r_cnt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [W-1:0]             r_data;
  logic                     r_valid;
  logic                     r_last;
  logic                     r_busy;
  logic                     r_done;

  logic w_start_ok;
  logic w_fetch_hit;
  logic w_send_hs;
  logic w_at_last;
  logic w_finish;

  assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_fetch_hit = (r_state == S_FETCH) && (r_cnt == CNT_ONE);
  assign w_send_hs   = (r_state == S_SEND) && r_valid && bus.out_ready;
  assign w_at_last   = (r_addr == LAST_ADDR);

`ifdef READOUT_CHECKSUM_EN
  logic [W-1:0] r_csum;
  logic         w_chk_hs;

  assign w_chk_hs = (r_state == S_CHK) && r_valid && bus.out_ready;
  assign w_finish = w_chk_hs;

  // Accumulates every data word at its handshake; the last word is folded in when CHK is entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= '0;
    end else if (w_start_ok) begin
      r_csum <= '0;
    end else if (w_send_hs) begin
      r_csum <= r_csum ^ r_data;
    end
  end
`else
  assign w_finish = w_send_hs && w_at_last;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (r_cnt == CNT_ONE) r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_send_hs) r_state <= w_at_last ? S_AFTER_LAST : S_FETCH;
        end
`ifdef READOUT_CHECKSUM_EN
        S_CHK: begin
          if (w_chk_hs) r_state <= S_DONE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_start_ok || (w_send_hs && !w_at_last)) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == S_FETCH) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Increment is gated below the last address, so the bus never wraps even at full 2^AW depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (w_start_ok) begin
      r_addr <= '0;
    end else if (w_send_hs && !w_at_last) begin
      r_addr <= r_addr + ADDR_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (w_fetch_hit) begin
      r_data <= bus.ram_q;
`ifdef READOUT_CHECKSUM_EN
    end else if (w_send_hs && w_at_last) begin
      r_data <= r_csum ^ r_data;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (w_fetch_hit) begin
      r_valid <= 1'b1;
    end else if (w_send_hs) begin
`ifdef READOUT_CHECKSUM_EN
      r_valid <= w_at_last;
`else
      r_valid <= 1'b0;
`endif
`ifdef READOUT_CHECKSUM_EN
    end else if (w_chk_hs) begin
      r_valid <= 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
    end else if (w_send_hs && w_at_last) begin
      r_last <= 1'b1;
    end else if (w_chk_hs) begin
      r_last <= 1'b0;
`else
    end else if (w_fetch_hit) begin
      r_last <= w_at_last;
    end else if (w_send_hs) begin
      r_last <= 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (w_start_ok) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (w_finish) begin
      r_busy <= 1'b0;
      r_done <= 1'b1;
    end
  end

  assign bus.ram_addr  = r_addr;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_ram_readout_streamer.sv
// Bench for ram_readout_streamer: queue-based stream model plus directed cycle-exact vectors.
module tb_ram_readout_streamer;

  localparam int NOD   = 1;
  localparam int RB    = 4;
  localparam int W     = (NOD + 1) * RB;
  localparam int AW_A  = 2;
  localparam int MAX_A = 4;
  localparam int RL_A  = 2;
  localparam int AW_B  = 1;
  localparam int MAX_B = 1;
  localparam int RL_B  = 1;
`ifdef READOUT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int DONE_N = CSUM ? 13 : 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_start, a_busy, a_done;
  logic b_rst, b_start, b_busy, b_done;

  ram_readout_streamer_if #(.W(W), .AW(AW_A)) a_if ();
  ram_readout_streamer_if #(.W(W), .AW(AW_B)) b_if ();

  ram_readout_streamer #(
    .NO_OF_DIGITS(NOD), .RADIX_BITS(RB), .ADDRESS_WIDTH(AW_A),
    .MAX_RAM_ADDRESS(MAX_A), .READ_LATENCY(RL_A)
  ) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .bus(a_if.master),
    .o_busy(a_busy), .o_done(a_done)
  );

  ram_readout_streamer #(
    .NO_OF_DIGITS(NOD), .RADIX_BITS(RB), .ADDRESS_WIDTH(AW_B),
    .MAX_RAM_ADDRESS(MAX_B), .READ_LATENCY(RL_B)
  ) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .bus(b_if.master),
    .o_busy(b_busy), .o_done(b_done)
  );

  // RAM A: two-clock read (one address register, then array); RAM B: one-clock read.
  logic [W-1:0]    mem_a [MAX_A];
  logic [W-1:0]    mem_b [2];
  logic [AW_A-1:0] a_addr_d;
  always @(posedge clk) a_addr_d <= a_if.ram_addr;
  assign a_if.ram_q = mem_a[a_addr_d];
  assign b_if.ram_q = mem_b[b_if.ram_addr];

  logic [W-1:0] lit_a [4];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Stream model: expected words of an accepted readout, in order, with their last flags.
  logic [W-1:0] q_a [$];
  bit           ql_a [$];
  bit           mdone_a = 1'b0;
  logic [W-1:0] q_b [$];
  bit           ql_b [$];
  bit           mdone_b = 1'b0;

  task automatic push_a();
    logic [W-1:0] x = '0;
    for (int i = 0; i < MAX_A; i++) begin
      q_a.push_back(mem_a[i]);
      ql_a.push_back(!CSUM && (i == MAX_A - 1));
      x = x ^ mem_a[i];
    end
    if (CSUM) begin
      q_a.push_back(x);
      ql_a.push_back(1'b1);
    end
  endtask

  task automatic push_b();
    logic [W-1:0] x = '0;
    for (int i = 0; i < MAX_B; i++) begin
      q_b.push_back(mem_b[i]);
      ql_b.push_back(!CSUM && (i == MAX_B - 1));
      x = x ^ mem_b[i];
    end
    if (CSUM) begin
      q_b.push_back(x);
      ql_b.push_back(1'b1);
    end
  endtask

  always @(negedge clk) begin : cmp
    bit wa, wb;
    if (a_rst) begin
      chk("a_rst_outs", 32'({a_if.ram_addr, a_if.out_data, a_if.out_valid, a_if.out_last, a_busy, a_done}), 0);
      q_a.delete(); ql_a.delete(); mdone_a = 1'b0;
    end else begin
      wa = (q_a.size() > 0);
      chk("a_busy", 32'(a_busy), 32'(wa));
      chk("a_done", 32'(a_done), 32'(mdone_a));
      if (a_if.out_valid) begin
        if (!wa) chk("a_unexpected_valid", 32'(a_if.out_valid), 0);
        else begin
          chk("a_data", 32'(a_if.out_data), 32'(q_a[0]));
          chk("a_last", 32'(a_if.out_last), 32'(ql_a[0]));
          if (a_if.out_ready) begin
            void'(q_a.pop_front()); void'(ql_a.pop_front());
            if (q_a.size() == 0) mdone_a = 1'b1;
          end
        end
      end else chk("a_last_unqualified", 32'(a_if.out_last), 0);
      if (a_start && !wa) begin push_a(); mdone_a = 1'b0; end
    end
    if (b_rst) begin
      chk("b_rst_outs", 32'({b_if.ram_addr, b_if.out_data, b_if.out_valid, b_if.out_last, b_busy, b_done}), 0);
      q_b.delete(); ql_b.delete(); mdone_b = 1'b0;
    end else begin
      wb = (q_b.size() > 0);
      chk("b_busy", 32'(b_busy), 32'(wb));
      chk("b_done", 32'(b_done), 32'(mdone_b));
      if (b_if.out_valid) begin
        if (!wb) chk("b_unexpected_valid", 32'(b_if.out_valid), 0);
        else begin
          chk("b_data", 32'(b_if.out_data), 32'(q_b[0]));
          chk("b_last", 32'(b_if.out_last), 32'(ql_b[0]));
          if (b_if.out_ready) begin
            void'(q_b.pop_front()); void'(ql_b.pop_front());
            if (q_b.size() == 0) mdone_b = 1'b1;
          end
        end
      end
      if (b_start && !wb) begin push_b(); mdone_b = 1'b0; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input int limit);
    int k = 0;
    while (!a_done && k < limit) begin step(); k++; end
    chk("a_done_reached", 32'(a_done), 1);
  endtask

  // Full readout on DUT A with out_ready high; valid after edges 2,5,8,11 (+12 for checksum).
  task automatic run_a_full(input string tag);
    bit ev;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk({tag, "_busy_e0"}, 32'(a_busy), 1);
    chk({tag, "_done_e0"}, 32'(a_done), 0);
    for (int n = 1; n <= DONE_N; n++) begin
      step();
      ev = ((n <= 11) && (n % 3 == 2)) || (CSUM && (n == 12));
      chk($sformatf("%s_valid_e%0d", tag, n), 32'(a_if.out_valid), 32'(ev));
      chk($sformatf("%s_done_e%0d", tag, n), 32'(a_done), 32'(n == DONE_N));
      if (ev) begin
        chk($sformatf("%s_data_e%0d", tag, n), 32'(a_if.out_data), (n == 12) ? 32'h0F : 32'(lit_a[(n - 2) / 3]));
        chk($sformatf("%s_last_e%0d", tag, n), 32'(a_if.out_last), 32'(((n == 11) && !CSUM) || (n == 12)));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_a[0] = 8'h01; mem_a[1] = 8'h02; mem_a[2] = 8'h04; mem_a[3] = 8'h08;
    mem_b[0] = 8'h5A; mem_b[1] = 8'h00;
    lit_a[0] = 8'h01; lit_a[1] = 8'h02; lit_a[2] = 8'h04; lit_a[3] = 8'h08;
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_if.out_ready = 1'b1; b_if.out_ready = 1'b1;
    step(); step();
    chk("a_reset_addr", 32'(a_if.ram_addr), 0);
    chk("a_reset_valid", 32'(a_if.out_valid), 0);
    chk("a_reset_busy_done", 32'({a_busy, a_done}), 0);
    a_rst = 1'b0; b_rst = 1'b0;
    step();

    run_a_full("a_basic");
    step();

    // Stall: out_ready low for five sampled edges while 0x2 is presented.
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (5) step();
    chk("stall_pre_valid", 32'(a_if.out_valid), 1);
    chk("stall_pre_data", 32'(a_if.out_data), 32'h02);
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall_hold_valid_%0d", i), 32'(a_if.out_valid), 1);
      chk($sformatf("stall_hold_data_%0d", i), 32'(a_if.out_data), 32'h02);
      chk($sformatf("stall_hold_addr_%0d", i), 32'(a_if.ram_addr), 1);
    end
    a_if.out_ready = 1'b1;
    step(); chk("stall_hs_valid", 32'(a_if.out_valid), 0);
    step(); chk("stall_fetch_valid", 32'(a_if.out_valid), 0);
    step();
    chk("stall_next_valid", 32'(a_if.out_valid), 1);
    chk("stall_next_data", 32'(a_if.out_data), 32'h04);
    wait_done_a(30);
    step();

    // Asynchronous reset during FETCH of address 2.
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (7) step();
    chk("rst_pre_addr", 32'(a_if.ram_addr), 2);
    chk("rst_pre_valid", 32'(a_if.out_valid), 0);
    chk("rst_pre_busy", 32'(a_busy), 1);
    #2 a_rst = 1'b1;
    #1;
    chk("rst_async_outs", 32'({a_if.ram_addr, a_if.out_data, a_if.out_valid, a_if.out_last, a_busy, a_done}), 0);
    step(); step();
    a_rst = 1'b0;
    repeat (3) step();
    chk("rst_no_resume", 32'({a_busy, a_done, a_if.out_valid, a_if.ram_addr}), 0);
    run_a_full("a_after_rst");
    step();

    // start during SEND of address 1 is ignored; start in DONE gives a second full readout.
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (5) step();
    chk("ign_send_data", 32'(a_if.out_data), 32'h02);
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("ign_addr", 32'(a_if.ram_addr), 2);
    chk("ign_busy", 32'(a_busy), 1);
    step(); step();
    chk("ign_next_valid", 32'(a_if.out_valid), 1);
    chk("ign_next_data", 32'(a_if.out_data), 32'h04);
    wait_done_a(30);
    step();
    run_a_full("a_restart");

    // Single word, READ_LATENCY=1.
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_busy_e0", 32'(b_busy), 1);
    chk("b_valid_e0", 32'(b_if.out_valid), 0);
    step();
    chk("b_valid_e1", 32'(b_if.out_valid), 1);
    chk("b_data_e1", 32'(b_if.out_data), 32'h5A);
    chk("b_last_e1", 32'(b_if.out_last), 32'(!CSUM));
    step();
    chk("b_valid_e2", 32'(b_if.out_valid), 32'(CSUM));
    chk("b_done_e2", 32'(b_done), 32'(!CSUM));
    begin
      int k = 0;
      while (!b_done && k < 10) begin step(); k++; end
    end
    chk("b_done_reached", 32'(b_done), 1);
    step();

    chk("a_model_drained", 32'(q_a.size()), 0);
    chk("b_model_drained", 32'(q_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
